// File: rtl/uart_rx_arbiter_pkg.sv
// Shared constants for the UART receive-buffer read side: pointer/count widths
// and the arbiter FSM encodings.
package uart_rx_arbiter_pkg;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_GAP  = 1'b1;

  typedef logic [AW-1:0] addr_t;
  typedef logic [CW-1:0] count_t;

endpackage

// File: rtl/uart_rx_arbiter_if.sv
// Buffer-side and consumer-side signals of the receive arbiter, bundled so the
// arbiter (master) and its environment (slave) share one connection.
interface uart_rx_arbiter_if #(
  parameter int AW = uart_rx_arbiter_pkg::AW
);

  logic [AW-1:0] tail_addr;
  logic          data_rcvd;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_data;
  logic [1:0]    req;
  logic [1:0]    out_gnt;
  logic          out_valid;
  logic [7:0]    out_data;

  modport master (
    input  tail_addr, data_rcvd, buf_data, req,
    output buf_addr, out_gnt, out_valid, out_data
  );

  modport slave (
    output tail_addr, data_rcvd, buf_data, req,
    input  buf_addr, out_gnt, out_valid, out_data
  );

endinterface

// File: rtl/uart_rx_arbiter_rr_arb2.sv
// Two-way round-robin grant logic; purely combinational, the history bit
// (index of the last winner) is held by the parent.
module uart_rx_arbiter_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_arbiter.sv
// Read-side controller for the 8-entry UART receive buffer: tracks occupancy,
// handles overflow/flush and hands bytes to two consumers round-robin.
module uart_rx_arbiter
  import uart_rx_arbiter_pkg::*;
#(
  parameter int   AW         = uart_rx_arbiter_pkg::AW,
  parameter logic RESET_LAST = 1'b1
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          enable,
  output logic          rx_en,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  input  logic          ovf_clr,
  input  logic          flush,
  uart_rx_arbiter_if.master bus
);

  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] head;
  logic [AW-1:0] tail_q;
  logic [0:0]    state;
  logic          last_gnt;
  logic          arrive;
  logic          rd_ok;
  logic          ovf_hit;
  logic [1:0]    gnt;

  assign empty        = (count == '0);
  assign full         = (count == FULL_CNT);
  assign bus.buf_addr = head;
  assign arrive       = (bus.tail_addr != tail_q);
  assign ovf_hit      = arrive & full;

  // No read while the head slot is being overwritten by a full-buffer write.
  assign rd_ok = (state == S_IDLE) & ~empty & (|bus.req) & ~flush
               & ~(full & bus.data_rcvd);

  uart_rx_arbiter_rr_arb2 u_arb (
    .req      (bus.req),
    .last_gnt (last_gnt),
    .en       (rd_ok),
    .gnt      (gnt)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      head          <= '0;
      tail_q        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      bus.out_gnt   <= 2'b00;
      bus.out_valid <= 1'b0;
      bus.out_data  <= 8'h00;
      rx_en         <= 1'b0;
      last_gnt      <= RESET_LAST;
      state         <= S_IDLE;
    end else begin
      rx_en         <= enable;
      tail_q        <= bus.tail_addr;
      bus.out_gnt   <= gnt;
      bus.out_valid <= |gnt;
      if (flush) begin
        head     <= bus.tail_addr;
        count    <= '0;
        overflow <= 1'b0;
        state    <= S_IDLE;
      end else begin
        if (rd_ok) begin
          bus.out_data <= bus.buf_data;
          last_gnt     <= gnt[1];
          state        <= S_GAP;
        end else if (state == S_GAP) begin
          state <= S_IDLE;
        end
        // An overflowing write drops the oldest byte by moving head past it.
        if (rd_ok || ovf_hit)
          head <= head + 1'b1;
        if (arrive && !rd_ok && !full)
          count <= count + 1'b1;
        else if (rd_ok && !arrive)
          count <= count - 1'b1;
        if (ovf_hit)
          overflow <= 1'b1;
        else if (ovf_clr)
          overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_arbiter.sv
// Self-checking bench for uart_rx_arbiter: a byte-queue scoreboard checks every
// grant, a vector table covers fill/overflow/concurrent read-write.
module tb_uart_rx_arbiter;
  import uart_rx_arbiter_pkg::*;

  typedef struct {
    logic       adv;
    logic [7:0] data;
    logic [1:0] req;
    logic       rcvd;
    logic       clr;
    int         exp_count;
    logic       exp_ovf;
    int         exp_head;
  } vec_t;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          enable = 1'b0;
  logic          rx_en;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          ovf_clr = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] tb_tail = '0;
  logic [7:0]    mem [DEPTH];

  int         checks = 0;
  int         failures = 0;
  logic [7:0] sb [$];
  logic [1:0] gnt_log [$];
  logic       mlast = 1'b1;
  logic [1:0] req_prev = 2'b00;
  logic [1:0] exp_gnt;
  vec_t       vecs [24];

  uart_rx_arbiter_if bus ();

  assign bus.tail_addr = tb_tail;
  assign bus.buf_data  = mem[bus.buf_addr];

  uart_rx_arbiter #(.AW(AW), .RESET_LAST(1'b1)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .enable   (enable),
    .rx_en    (rx_en),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .flush    (flush),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Grant-side monitor: req at the previous falling edge is what the grant edge saw.
  always @(negedge clk) begin
    if (nrst) begin
      checkVal("valid_vs_gnt", bus.out_valid, |bus.out_gnt);
      if (bus.out_valid) begin
        exp_gnt = (req_prev == 2'b11) ? (mlast ? 2'b01 : 2'b10) : req_prev;
        checkVal("grant", bus.out_gnt, exp_gnt);
        mlast = exp_gnt[1];
        gnt_log.push_back(bus.out_gnt);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_grant: got data %0h expected no grant", bus.out_data);
        end else begin
          checkVal("out_data", bus.out_data, sb.pop_front());
        end
      end
    end
    req_prev = bus.req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushByte(input logic [7:0] d);
    mem[tb_tail] = d;
    if (sb.size() == DEPTH)
      void'(sb.pop_front());
    sb.push_back(d);
    tb_tail = tb_tail + 1'b1;
  endtask

  task automatic checkReset(input string tag);
    checkVal({tag, "_count"}, count, 0);
    checkVal({tag, "_empty"}, empty, 1);
    checkVal({tag, "_full"}, full, 0);
    checkVal({tag, "_ovf"}, overflow, 0);
    checkVal({tag, "_valid"}, bus.out_valid, 0);
    checkVal({tag, "_gnt"}, bus.out_gnt, 0);
    checkVal({tag, "_data"}, bus.out_data, 0);
    checkVal({tag, "_rx_en"}, rx_en, 0);
    checkVal({tag, "_addr"}, bus.buf_addr, 0);
  endtask

  task automatic doReset(input int n, input string tag);
    nrst = 1'b0;
    tb_tail = '0;
    bus.req = 2'b00;
    bus.data_rcvd = 1'b0;
    flush = 1'b0;
    ovf_clr = 1'b0;
    sb.delete();
    gnt_log.delete();
    mlast = 1'b1;
    repeat (n) tick();
    checkReset(tag);
    nrst = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.data_rcvd = v.rcvd;
    bus.req = v.req;
    ovf_clr = v.clr;
    if (v.adv)
      pushByte(v.data);
    tick();
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkVal($sformatf("row%0d_count", idx), count, v.exp_count);
    checkVal($sformatf("row%0d_ovf", idx), overflow, v.exp_ovf);
    checkVal($sformatf("row%0d_head", idx), bus.buf_addr, v.exp_head);
    checkVal($sformatf("row%0d_full", idx), full, v.exp_count == DEPTH);
    checkVal($sformatf("row%0d_empty", idx), empty, v.exp_count == 0);
  endtask

  function automatic vec_t mk(logic adv, logic [7:0] data, logic [1:0] req, logic rcvd,
                              logic clr, int ec, logic eo, int eh);
    vec_t v;
    v.adv = adv; v.data = data; v.req = req; v.rcvd = rcvd; v.clr = clr;
    v.exp_count = ec; v.exp_ovf = eo; v.exp_head = eh;
    return v;
  endfunction

  initial begin
    int n0;
    foreach (mem[i]) mem[i] = 8'h00;
    bus.req = 2'b00;
    bus.data_rcvd = 1'b0;

    // Fill to 8, overflow twice (second with a coincident clear), drain to 4, then read+write together.
    for (int i = 0; i < 8; i++)
      vecs[i] = mk(1'b1, 8'hC0 + 8'(i), 2'b00, 1'b0, 1'b0, i + 1, 1'b0, 0);
    vecs[8]  = mk(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 8, 1'b0, 0);
    vecs[9]  = mk(1'b1, 8'hD8, 2'b11, 1'b1, 1'b0, 8, 1'b1, 1);
    vecs[10] = mk(1'b0, 8'h00, 2'b11, 1'b1, 1'b0, 8, 1'b1, 1);
    vecs[11] = mk(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 8, 1'b0, 1);
    vecs[12] = mk(1'b1, 8'hD9, 2'b00, 1'b1, 1'b1, 8, 1'b1, 2);
    vecs[13] = mk(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 8, 1'b0, 2);
    vecs[14] = mk(1'b0, 8'h00, 2'b01, 1'b0, 1'b0, 7, 1'b0, 3);
    vecs[15] = mk(1'b0, 8'h00, 2'b01, 1'b0, 1'b0, 7, 1'b0, 3);
    vecs[16] = mk(1'b0, 8'h00, 2'b01, 1'b0, 1'b0, 6, 1'b0, 4);
    vecs[17] = mk(1'b0, 8'h00, 2'b01, 1'b0, 1'b0, 6, 1'b0, 4);
    vecs[18] = mk(1'b0, 8'h00, 2'b01, 1'b0, 1'b0, 5, 1'b0, 5);
    vecs[19] = mk(1'b0, 8'h00, 2'b01, 1'b0, 1'b0, 5, 1'b0, 5);
    vecs[20] = mk(1'b0, 8'h00, 2'b01, 1'b0, 1'b0, 4, 1'b0, 6);
    vecs[21] = mk(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 4, 1'b0, 6);
    vecs[22] = mk(1'b1, 8'hDA, 2'b01, 1'b0, 1'b0, 4, 1'b0, 7);
    vecs[23] = mk(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 4, 1'b0, 7);

    doReset(3, "rst0");
    enable = 1'b1;
    tick();
    checkVal("rx_en_follow", rx_en, 1);

    // Single byte to requester 0.
    bus.req = 2'b01;
    pushByte(8'hA5);
    tick();
    checkVal("t1_count_up", count, 1);
    tick();
    checkVal("t1_gnt", bus.out_gnt, 2'b01);
    checkVal("t1_data", bus.out_data, 8'hA5);
    checkVal("t1_count_dn", count, 0);
    checkVal("t1_addr", bus.buf_addr, 1);
    bus.req = 2'b00;
    tick();

    // Round-robin from a fresh history bit.
    doReset(2, "rst1");
    bus.req = 2'b11;
    pushByte(8'hB1); tick();
    pushByte(8'hB2); tick();
    pushByte(8'hB3); tick();
    repeat (8) tick();
    checkVal("t2_count", count, 0);
    checkVal("t2_empty", empty, 1);
    checkVal("t2_ngrants", gnt_log.size(), 3);
    if (gnt_log.size() == 3) begin
      checkVal("t2_gnt0", gnt_log[0], 2'b01);
      checkVal("t2_gnt1", gnt_log[1], 2'b10);
      checkVal("t2_gnt2", gnt_log[2], 2'b01);
    end

    doReset(2, "rst2");
    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    bus.req = 2'b10;
    for (int i = 0; i < 20 && count != 0; i++)
      tick();
    tick();
    checkVal("drain_count", count, 0);
    checkVal("drain_sb", sb.size(), 0);
    checkVal("drain_addr", bus.buf_addr, tb_tail);

    // Twelve write/read pairs walk the pointers past the wrap point.
    n0 = gnt_log.size();
    bus.req = 2'b01;
    for (int i = 0; i < 12; i++) begin
      pushByte(8'hE0 + 8'(i));
      tick();
      tick();
    end
    tick();
    checkVal("wrap_grants", gnt_log.size() - n0, 12);
    checkVal("wrap_count", count, 0);
    checkVal("wrap_ovf", overflow, 0);
    checkVal("wrap_addr", bus.buf_addr, tb_tail);

    bus.req = 2'b00;
    for (int i = 0; i < 5; i++) begin
      pushByte(8'h50 + 8'(i));
      tick();
    end
    checkVal("t6_count5", count, 5);
    pushByte(8'hFF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    checkVal("flush_count", count, 0);
    checkVal("flush_empty", empty, 1);
    checkVal("flush_addr", bus.buf_addr, tb_tail);
    checkVal("flush_valid", bus.out_valid, 0);
    tick();
    checkVal("flush_no_ghost", count, 0);

    bus.req = 2'b01;
    pushByte(8'h77);
    tick();
    tick();
    checkVal("gap_valid", bus.out_valid, 1);
    doReset(1, "rst_gap");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
